// File: rtl/gb_cpu_cb_hl_seq_if.sv
// Memory handshake bus between the CB (HL) sequencer and the memory system.
// Requests are level-held until mem_ack; read data is valid alongside mem_ack.
interface gb_cpu_cb_hl_seq_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/gb_cpu_cb_hl_seq.sv
// Read-modify-write sequencer for CB-prefixed ops on (HL): fetch byte, run one ALU
// cycle, write back (except BIT), then report the new flags.
package gb_cpu_alu_pkg;
  typedef enum logic [3:0] {
    ADD,
    ROTL,
    ROTR,
    ROTL_CARRY,
    ROTR_CARRY,
    SHIFT_L,
    SHIFT_R_ARITH,
    SWAP,
    SHIFT_R_LOGIC,
    BIT,
    RESET,
    SET
  } alu_op_e;

  typedef struct packed {
    alu_op_e    opcode;
    logic [2:0] dst;
    logic [2:0] src;
    logic       use_imm;
  } gb_instruction_t;
endpackage

module gb_cpu_cb_hl_seq
  import gb_cpu_alu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            cb_op,
  input  logic [15:0]           hl,
  input  logic [3:0]            flags_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  gb_cpu_cb_hl_seq_if.master    mem,
  output gb_instruction_t       alu_instr,
  output logic [7:0]            alu_in0,
  output logic [7:0]            alu_in1,
  output logic                  alu_carry_in,
  input  logic [7:0]            alu_out,
  input  logic                  alu_z,
  input  logic                  alu_n,
  input  logic                  alu_h,
  input  logic                  alu_c,
  output logic [3:0]            flags_out,
  output logic                  flags_we
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWrite, StDone} state_e;

  localparam logic [15:0] WaitLast = 16'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;      // cb_op[7:3]: group and bit/shift index
  logic [15:0] hl_q, hl_d;
  logic [3:0]  fin_q, fin_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  alu_op_e     opc_q, opc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        is_bit;

  function automatic alu_op_e decode_op(input logic [4:0] op);
    alu_op_e d;
    d = ADD;
    unique case (op[4:3])
      2'b00: begin
        unique case (op[2:0])
          3'd0: d = ROTL;
          3'd1: d = ROTR;
          3'd2: d = ROTL_CARRY;
          3'd3: d = ROTR_CARRY;
          3'd4: d = SHIFT_L;
          3'd5: d = SHIFT_R_ARITH;
          3'd6: d = SWAP;
          3'd7: d = SHIFT_R_LOGIC;
        endcase
      end
      2'b01:   d = BIT;
      2'b10:   d = RESET;
      default: d = SET;
    endcase
    return d;
  endfunction

  assign is_bit = (op_q[4:3] == 2'b01);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hl_d     = hl_q;
    fin_d    = fin_q;
    data_d   = data_q;
    result_d = result_q;
    flags_d  = flags_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cb_op[2:0] != 3'b110) begin
            err_d = 1'b1;
          end else begin
            op_d    = cb_op[7:3];
            hl_d    = hl;
            fin_d   = flags_in;
            opc_d   = decode_op(cb_op[7:3]);
            cnt_d   = '0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (mem.mem_ack) begin
          data_d  = mem.mem_rdata;
          state_d = StExec;
        end else if (cnt_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StExec: begin
        result_d = alu_out;
        unique case (op_q[4:3])
          2'b00:   flags_d = {alu_z, alu_n, alu_h, alu_c};
          2'b01:   flags_d = {alu_z, 1'b0, 1'b1, fin_q[0]};
          default: flags_d = fin_q;
        endcase
        cnt_d   = '0;
        state_d = is_bit ? StDone : StWrite;
      end
      StWrite: begin
        if (mem.mem_ack) begin
          state_d = StDone;
        end else if (cnt_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      hl_q     <= '0;
      fin_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      opc_q    <= ADD;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hl_q     <= hl_d;
      fin_q    <= fin_d;
      data_q   <= data_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      opc_q    <= opc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign mem.mem_addr  = hl_q;
  assign mem.mem_rd    = (state_q == StRead);
  assign mem.mem_wr    = (state_q == StWrite);
  assign mem.mem_wdata = result_q;

  // ALU inputs are meaningful only in StExec but stay at their latched values otherwise.
  always_comb begin
    alu_instr        = '0;
    alu_instr.opcode = opc_q;
  end
  assign alu_in0      = data_q;
  assign alu_in1      = {5'b0, op_q[2:0]};
  assign alu_carry_in = fin_q[0];

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign flags_out = flags_q;
  // RES/SET leave the flag register untouched.
  assign flags_we  = (state_q == StDone) && !op_q[4];

endmodule

// File: tb/tb_gb_cpu_cb_hl_seq.sv
// Bench for gb_cpu_cb_hl_seq: timeline model of each operation checked every cycle,
// plus literal expectations for the directed vectors.
module tb_gb_cpu_cb_hl_seq;
  import gb_cpu_alu_pkg::*;

  localparam int TbWait = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [7:0]      cb_op = 8'h00;
  logic [15:0]     hl = 16'h0000;
  logic [3:0]      flags_in = 4'h0;
  logic            busy, done, err, flags_we;
  logic [3:0]      flags_out;
  gb_instruction_t alu_instr;
  logic [7:0]      alu_in0, alu_in1;
  logic            alu_carry_in;
  logic [7:0]      alu_out;
  logic            alu_z, alu_n, alu_h, alu_c;

  gb_cpu_cb_hl_seq_if mem_a ();

  gb_cpu_cb_hl_seq #(.WAIT_MAX(TbWait)) dut (
    .clk(clk), .reset(reset), .start(start), .cb_op(cb_op), .hl(hl), .flags_in(flags_in),
    .busy(busy), .done(done), .err(err), .mem(mem_a),
    .alu_instr(alu_instr), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_h(alu_h), .alu_c(alu_c),
    .flags_out(flags_out), .flags_we(flags_we)
  );

  // Second instance with a short wait limit, never acknowledged.
  logic            start2 = 1'b0;
  logic            busy2, done2, err2, fw2, ci2;
  logic [3:0]      fo2;
  gb_instruction_t instr2;
  logic [7:0]      in0_2, in1_2;

  gb_cpu_cb_hl_seq_if mem_b ();
  assign mem_b.mem_ack   = 1'b0;
  assign mem_b.mem_rdata = 8'h00;

  gb_cpu_cb_hl_seq #(.WAIT_MAX(4)) dut_to (
    .clk(clk), .reset(reset), .start(start2), .cb_op(8'h36), .hl(16'hC100),
    .flags_in(4'h0), .busy(busy2), .done(done2), .err(err2), .mem(mem_b),
    .alu_instr(instr2), .alu_in0(in0_2), .alu_in1(in1_2), .alu_carry_in(ci2),
    .alu_out(8'h00), .alu_z(1'b0), .alu_n(1'b0), .alu_h(1'b0), .alu_c(1'b0),
    .flags_out(fo2), .flags_we(fw2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack after a programmed number of waiting cycles.
  int         rd_wait = 0, wr_wait = 0, req_cnt = 0;
  logic [7:0] rd_data = 8'h00;
  logic       stray_ack = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) req_cnt <= 0;
    else req_cnt <= (mem_a.mem_rd || mem_a.mem_wr) ? req_cnt + 1 : 0;
  end
  assign mem_a.mem_ack = stray_ack || (mem_a.mem_rd && req_cnt == rd_wait) ||
                         (mem_a.mem_wr && req_cnt == wr_wait);
  assign mem_a.mem_rdata = rd_data;

  // Behavioural ALU.
  always_comb begin
    logic [7:0] a;
    logic [2:0] b;
    a     = alu_in0;
    b     = alu_in1[2:0];
    alu_out = a;
    alu_n = 1'b0;
    alu_h = 1'b0;
    alu_c = 1'b0;
    case (alu_instr.opcode)
      ROTL:          begin alu_out = {a[6:0], a[7]};         alu_c = a[7]; end
      ROTR:          begin alu_out = {a[0], a[7:1]};         alu_c = a[0]; end
      ROTL_CARRY:    begin alu_out = {a[6:0], alu_carry_in}; alu_c = a[7]; end
      ROTR_CARRY:    begin alu_out = {alu_carry_in, a[7:1]}; alu_c = a[0]; end
      SHIFT_L:       begin alu_out = a << 1;                 alu_c = a[7]; end
      SHIFT_R_ARITH: begin alu_out = {a[7], a[7:1]};         alu_c = a[0]; end
      SWAP:          alu_out = {a[3:0], a[7:4]};
      SHIFT_R_LOGIC: begin alu_out = a >> 1;                 alu_c = a[0]; end
      BIT:           begin alu_h = 1'b1; alu_c = alu_carry_in; end
      RESET:         alu_out = a & ~(8'h01 << b);
      SET:           alu_out = a | (8'h01 << b);
      default:       alu_out = a + alu_in1;
    endcase
    alu_z = (alu_instr.opcode == BIT) ? ~a[b] : (alu_out == 8'h00);
  end

  int n_chk = 0, n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Timeline model of the current operation (cycle numbers, -1 = none).
  int         m_s, m_rd_lo, m_rd_hi, m_exec, m_wr_lo, m_wr_hi, m_done, m_err, m_last, m_end;
  logic [7:0] m_op, m_data, m_wdata;
  logic [15:0] m_addr;
  logic [3:0] m_fl, m_flags;
  logic       m_we;

  function automatic bit in_rng(input int c, input int lo, input int hi);
    return (lo >= 0) && (c >= lo) && (c <= hi);
  endfunction

  function automatic void ref_op(input logic [7:0] op, input logic [7:0] d,
                                 input logic [3:0] fl, output logic [7:0] res,
                                 output logic [3:0] f);
    logic [2:0] b;
    logic       c;
    b = op[5:3];
    c = 1'b0;
    res = d;
    case (op[7:6])
      2'b01: f = {~d[b], 1'b0, 1'b1, fl[0]};
      2'b10: begin res = d & ~(8'h01 << b); f = fl; end
      2'b11: begin res = d | (8'h01 << b); f = fl; end
      default: begin
        case (b)
          3'd0: begin res = {d[6:0], d[7]};  c = d[7]; end
          3'd1: begin res = {d[0], d[7:1]};  c = d[0]; end
          3'd2: begin res = {d[6:0], fl[0]}; c = d[7]; end
          3'd3: begin res = {fl[0], d[7:1]}; c = d[0]; end
          3'd4: begin res = {d[6:0], 1'b0};  c = d[7]; end
          3'd5: begin res = {d[7], d[7:1]};  c = d[0]; end
          3'd6: res = {d[3:0], d[7:4]};
          default: begin res = {1'b0, d[7:1]}; c = d[0]; end
        endcase
        f = {res == 8'h00, 1'b0, 1'b0, c};
      end
    endcase
  endfunction

  alu_op_e shift_tab [8] = '{ROTL, ROTR, ROTL_CARRY, ROTR_CARRY, SHIFT_L, SHIFT_R_ARITH,
                             SWAP, SHIFT_R_LOGIC};

  function automatic alu_op_e exp_opc(input logic [7:0] op);
    case (op[7:6])
      2'b00:   return shift_tab[op[5:3]];
      2'b01:   return BIT;
      2'b10:   return RESET;
      default: return SET;
    endcase
  endfunction

  task automatic clear_model();
    m_s = -1; m_rd_lo = -1; m_rd_hi = -1; m_exec = -1; m_wr_lo = -1; m_wr_hi = -1;
    m_done = -1; m_err = -1; m_last = -1; m_end = -1; m_we = 1'b0;
  endtask

  task automatic set_model(input int s, input logic [7:0] op, input logic [15:0] addr,
                           input logic [3:0] fl, input logic [7:0] data,
                           input int rdw, input int wrw);
    clear_model();
    m_s = s; m_op = op; m_addr = addr; m_fl = fl; m_data = data;
    if (op[2:0] != 3'b110) begin
      m_err = s + 1;
      m_end = s + 1;
    end else if (rdw >= TbWait) begin
      m_rd_lo = s + 1; m_rd_hi = s + TbWait; m_err = m_rd_hi + 1;
      m_last = m_rd_hi; m_end = m_err;
    end else begin
      m_rd_lo = s + 1; m_rd_hi = s + 1 + rdw; m_exec = m_rd_hi + 1;
      ref_op(op, data, fl, m_wdata, m_flags);
      m_we = !op[7];
      if (op[7:6] == 2'b01) begin
        m_done = m_exec + 1;
      end else begin
        m_wr_lo = m_exec + 1; m_wr_hi = m_wr_lo + wrw; m_done = m_wr_hi + 1;
      end
      m_last = m_done; m_end = m_done;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("busy", 16'(busy), 16'(in_rng(cyc, m_s + 1, m_last)));
      chk("done", 16'(done), 16'(cyc == m_done));
      chk("err", 16'(err), 16'(cyc == m_err));
      chk("flags_we", 16'(flags_we), 16'((cyc == m_done) && m_we));
      chk("mem_rd", 16'(mem_a.mem_rd), 16'(in_rng(cyc, m_rd_lo, m_rd_hi)));
      chk("mem_wr", 16'(mem_a.mem_wr), 16'(in_rng(cyc, m_wr_lo, m_wr_hi)));
      if (in_rng(cyc, m_rd_lo, m_rd_hi) || in_rng(cyc, m_wr_lo, m_wr_hi))
        chk("mem_addr", mem_a.mem_addr, m_addr);
      if (in_rng(cyc, m_wr_lo, m_wr_hi)) chk("mem_wdata", 16'(mem_a.mem_wdata), 16'(m_wdata));
      if (cyc == m_done) chk("flags_out", 16'(flags_out), 16'(m_flags));
      if (cyc == m_exec) begin
        chk("alu_opcode", 16'(alu_instr.opcode), 16'(exp_opc(m_op)));
        chk("alu_in0", 16'(alu_in0), 16'(m_data));
        chk("alu_in1", 16'(alu_in1), 16'(m_op[5:3]));
        chk("alu_carry_in", 16'(alu_carry_in), 16'(m_fl[0]));
      end
    end
  end

  // Records of what the DUT actually did, for the literal expectations.
  int          n_wr = 0, last_done = -1, last_err = -1;
  logic [7:0]  last_wdata = 8'h00;
  logic [15:0] last_waddr = 16'h0000;
  logic [3:0]  last_flags = 4'h0;
  logic        last_we = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_a.mem_wr && mem_a.mem_ack) begin
        n_wr       <= n_wr + 1;
        last_wdata <= mem_a.mem_wdata;
        last_waddr <= mem_a.mem_addr;
      end
      if (done) begin
        last_done  <= cyc;
        last_flags <= flags_out;
        last_we    <= flags_we;
      end
      if (err) last_err <= cyc;
    end
  end

  task automatic wait_end();
    while (cyc < m_end + 2) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] addr, input logic [3:0] fl,
                       input logic [7:0] data, input int rdw, input int wrw);
    @(posedge clk); #1;
    cb_op = op; hl = addr; flags_in = fl; rd_data = data; rd_wait = rdw; wr_wait = wrw;
    start = 1'b1;
    set_model(cyc, op, addr, fl, data, rdw, wrw);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] op, input logic [15:0] addr, input logic [3:0] fl,
                        input logic [7:0] data, input int rdw, input int wrw);
    issue(op, addr, fl, data, rdw, wrw);
    wait_end();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_done"}, 16'(done), 16'h0);
    chk({tag, "_err"}, 16'(err), 16'h0);
    chk({tag, "_rd"}, 16'(mem_a.mem_rd), 16'h0);
    chk({tag, "_wr"}, 16'(mem_a.mem_wr), 16'h0);
    chk({tag, "_addr"}, mem_a.mem_addr, 16'h0);
    chk({tag, "_wdata"}, 16'(mem_a.mem_wdata), 16'h0);
    chk({tag, "_flags"}, 16'(flags_out), 16'h0);
    chk({tag, "_we"}, 16'(flags_we), 16'h0);
    chk({tag, "_instr"}, 16'(alu_instr), 16'h0);
    chk({tag, "_in0"}, 16'(alu_in0), 16'h0);
    chk({tag, "_in1"}, 16'(alu_in1), 16'h0);
    chk({tag, "_cin"}, 16'(alu_carry_in), 16'h0);
  endtask

  logic [7:0] t_op   [7] = '{8'h0E, 8'h1E, 8'h26, 8'h2E, 8'h3E, 8'h96, 8'h46};
  logic [7:0] t_data [7] = '{8'h01, 8'h01, 8'hC3, 8'h81, 8'h01, 8'hFF, 8'h01};
  logic [3:0] t_fl   [7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0};
  logic [7:0] t_wd   [7] = '{8'h80, 8'h00, 8'h86, 8'hC0, 8'h00, 8'hFB, 8'h00};
  logic [3:0] t_f    [7] = '{4'h1, 4'h9, 4'h1, 4'h1, 4'h9, 4'hA, 4'h2};
  logic       t_wr   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  int w0, s2, rdc, errc, errn, dn;
  logic busy_at;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Ack with no request outstanding must change nothing.
    stray_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_ack = 1'b0;

    run_op(8'h36, 16'hC000, 4'h0, 8'hA5, 0, 0);
    chk("swap_wdata", 16'(last_wdata), 16'h005A);
    chk("swap_waddr", last_waddr, 16'hC000);
    chk("swap_flags", 16'(last_flags), 16'h0000);
    chk("swap_we", 16'(last_we), 16'h0001);
    chk("swap_latency", 16'(last_done - m_s), 16'd4);

    run_op(8'h16, 16'hC001, 4'b0001, 8'h80, 0, 0);
    chk("rl1_wdata", 16'(last_wdata), 16'h0001);
    chk("rl1_flags", 16'(last_flags), 16'b0001);
    run_op(8'h16, 16'hC002, 4'b0000, 8'h00, 0, 0);
    chk("rl2_wdata", 16'(last_wdata), 16'h0000);
    chk("rl2_flags", 16'(last_flags), 16'b1000);

    w0 = n_wr;
    run_op(8'h7E, 16'hC003, 4'b0001, 8'h7F, 0, 0);
    chk("bit_no_write", 16'(n_wr - w0), 16'd0);
    chk("bit_flags", 16'(last_flags), 16'b1011);
    chk("bit_latency", 16'(last_done - m_s), 16'd3);

    run_op(8'hDE, 16'hC020, 4'b0110, 8'h00, 5, 4);
    chk("set_wdata", 16'(last_wdata), 16'h0008);
    chk("set_we", 16'(last_we), 16'h0000);
    chk("set_latency", 16'(last_done - m_s), 16'd13);

    // Ack on the last permitted waiting cycle still completes.
    run_op(8'h36, 16'hC010, 4'h0, 8'h0F, TbWait - 1, TbWait - 1);
    chk("edge_wdata", 16'(last_wdata), 16'h00F0);
    chk("edge_latency", 16'(last_done - m_s), 16'(2 * TbWait + 2));

    for (int i = 0; i < 7; i++) begin
      w0 = n_wr;
      run_op(t_op[i], 16'(16'hC100 + i), t_fl[i], t_data[i], i % 3, (i + 1) % 3);
      chk("tab_flags", 16'(last_flags), 16'(t_f[i]));
      chk("tab_writes", 16'(n_wr - w0), 16'(t_wr[i]));
      if (t_wr[i]) chk("tab_wdata", 16'(last_wdata), 16'(t_wd[i]));
    end

    w0 = n_wr;
    run_op(8'h37, 16'hC200, 4'h0, 8'h55, 0, 0);
    chk("illegal_err_cycle", 16'(last_err - m_s), 16'd1);
    chk("illegal_no_write", 16'(n_wr - w0), 16'd0);

    // A second start while busy must be ignored.
    issue(8'h06, 16'hD000, 4'h0, 8'h81, 3, 1);
    @(posedge clk); #1;
    cb_op = 8'h7E; hl = 16'h1234; flags_in = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end();
    chk("busy_start_wdata", 16'(last_wdata), 16'h0003);
    chk("busy_start_waddr", last_waddr, 16'hD000);
    chk("busy_start_flags", 16'(last_flags), 16'b0001);

    // Reset while a write is pending.
    w0 = n_wr;
    issue(8'h36, 16'hC300, 4'h0, 8'h12, 0, 25);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_wr", 16'(mem_a.mem_wr), 16'h1);
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_dropped_write", 16'(n_wr - w0), 16'd0);

    // Timeout on the WAIT_MAX=4 instance.
    @(posedge clk); #1;
    start2 = 1'b1;
    s2 = cyc;
    @(posedge clk); #1;
    start2 = 1'b0;
    rdc = 0; errc = -1; errn = 0; dn = 0; busy_at = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_b.mem_rd) rdc++;
      if (err2) begin errc = cyc; errn++; end
      if (done2 || fw2) dn++;
      if (cyc == s2 + 5) busy_at = busy2;
    end
    chk("to_rd_cycles", 16'(rdc), 16'd4);
    chk("to_err_cycle", 16'(errc - s2), 16'd5);
    chk("to_err_count", 16'(errn), 16'd1);
    chk("to_no_done", 16'(dn), 16'd0);
    chk("to_idle", 16'(busy_at), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
